// File: rtl/mitch_div.sv
// Pipelined Mitchell logarithmic approximate divider: q ~= a / b, W integer + FRAC fraction bits.
// Build option MITCH_DIV_ROUND_EN: right-shifted quotients round to nearest instead of truncating.
module mitch_div #(
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W+FRAC-1:0] q,
    output logic              dbz
);
    localparam int KW = $clog2(W);
    localparam int QW = W + FRAC;
    // The antilog shift is biased by RS so it is always a left shift; the
    // quotient is then the window [RS +: QW] of the shifted mantissa.
    localparam int RS = 2 * W - 1;
    localparam int BW = 3 * W + FRAC + 1;
    localparam int SW = $clog2(BW) + 1;

`ifdef MITCH_DIV_ROUND_EN
    localparam logic [BW-1:0] RND = BW'(1) << (RS - 1);
`else
    localparam logic [BW-1:0] RND = '0;
`endif

    function automatic logic [KW-1:0] lead_one(input logic [W-1:0] x);
        lead_one = '0;
        for (int i = 0; i < W; i++)
            if (x[i]) lead_one = KW'(i);
    endfunction

    logic          en;
    logic [3:0]    vld_pipe_q, vld_pipe_d;

    // S1: captured operands
    logic [W-1:0]  a1_q, a1_d, b1_q, b1_d;

    // S2: log domain
    logic [KW-1:0] k1_q, k1_d, k2_q, k2_d;
    logic [W-2:0]  f1_q, f1_d, f2_q, f2_d;
    logic          za2_q, za2_d, zb2_q, zb2_d;

    // S3: mantissa and biased shift amount
    logic [W-1:0]  m3_q, m3_d;
    logic [SW-1:0] sh3_q, sh3_d;
    logic          za3_q, za3_d, zb3_q, zb3_d;

    // Output register
    logic [QW-1:0] q_q, q_d;
    logic          dbz_q, dbz_d;

    logic [KW-1:0] k1_c, k2_c;
    logic [W-2:0]  f1_c, f2_c;
    logic [W-1:0]  d_c, m_c;
    logic          borrow_c;
    logic [SW-1:0] sh_c;
    logic [BW-1:0] big_c, qf_c;
    logic          sat_c;
    logic [QW-1:0] q_c;

    always_comb begin
        k1_c     = lead_one(a1_q);
        k2_c     = lead_one(b1_q);
        f1_c     = (W-1)'(a1_q << (KW'(W - 1) - k1_c));
        f2_c     = (W-1)'(b1_q << (KW'(W - 1) - k2_c));

        // With a borrow, the W-bit wrap of f1-f2 is already 2+f1-f2 in 1.x form.
        d_c      = W'(f1_q) - W'(f2_q);
        borrow_c = f1_q < f2_q;
        m_c      = borrow_c ? d_c : (d_c | (W'(1) << (W - 1)));
        sh_c     = SW'(k1_q) + SW'(FRAC + W) - SW'(k2_q) - SW'(borrow_c);

        big_c    = (BW'(m3_q) << sh3_q) + RND;
        qf_c     = big_c >> RS;
        sat_c    = |qf_c[BW-1:QW];
        if (zb3_q)      q_c = '1;
        else if (za3_q) q_c = '0;
        else if (sat_c) q_c = '1;
        else            q_c = qf_c[QW-1:0];
    end

    always_comb begin
        en         = !vld_pipe_q[3] || out_ready;
        vld_pipe_d = vld_pipe_q;
        a1_d  = a1_q;  b1_d  = b1_q;
        k1_d  = k1_q;  k2_d  = k2_q;
        f1_d  = f1_q;  f2_d  = f2_q;
        za2_d = za2_q; zb2_d = zb2_q;
        m3_d  = m3_q;  sh3_d = sh3_q;
        za3_d = za3_q; zb3_d = zb3_q;
        q_d   = q_q;   dbz_d = dbz_q;
        if (en) begin
            vld_pipe_d = {vld_pipe_q[2:0], in_valid};
            a1_d  = a;
            b1_d  = b;
            k1_d  = k1_c;
            k2_d  = k2_c;
            f1_d  = f1_c;
            f2_d  = f2_c;
            za2_d = (a1_q == '0);
            zb2_d = (b1_q == '0);
            m3_d  = m_c;
            sh3_d = sh_c;
            za3_d = za2_q;
            zb3_d = zb2_q;
            q_d   = q_c;
            dbz_d = zb3_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            a1_q  <= '0; b1_q  <= '0;
            k1_q  <= '0; k2_q  <= '0;
            f1_q  <= '0; f2_q  <= '0;
            za2_q <= 1'b0; zb2_q <= 1'b0;
            m3_q  <= '0; sh3_q <= '0;
            za3_q <= 1'b0; zb3_q <= 1'b0;
            q_q   <= '0; dbz_q <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            a1_q  <= a1_d;  b1_q  <= b1_d;
            k1_q  <= k1_d;  k2_q  <= k2_d;
            f1_q  <= f1_d;  f2_q  <= f2_d;
            za2_q <= za2_d; zb2_q <= zb2_d;
            m3_q  <= m3_d;  sh3_q <= sh3_d;
            za3_q <= za3_d; zb3_q <= zb3_d;
            q_q   <= q_d;   dbz_q <= dbz_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = vld_pipe_q[3];
    assign q         = q_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_mitch_div.sv
// Scoreboard bench for mitch_div: directed vectors, random stream, backpressure and mid-flight reset.
module tb_mitch_div;
    localparam int W    = 16;
    localparam int FRAC = 8;
    localparam int QW   = W + FRAC;

    typedef struct packed {
        logic [QW-1:0] q;
        logic          dbz;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, dbz;
    logic [W-1:0]  a, b;
    logic [QW-1:0] q;

    res_t exp_q[$];
    res_t e_pop;
    int   n_chk  = 0;
    int   n_pass = 0;

    mitch_div #(.W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .dbz(dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every handshaken result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_result: got q=%h dbz=%b, required no result", q, dbz);
            end else begin
                e_pop = exp_q.pop_front();
                if (q !== e_pop.q || dbz !== e_pop.dbz)
                    $display("FAIL result: got q=%h dbz=%b, required q=%h dbz=%b",
                             q, dbz, e_pop.q, e_pop.dbz);
                else
                    n_pass++;
            end
        end
    end

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) repeat (e) r = r * 2.0;
        else        repeat (-e) r = r / 2.0;
        return r;
    endfunction

    // Real-valued Mitchell reference, independent of the hardware bit tricks.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        res_t   r;
        int     k1, k2;
        real    f1, f2, v, s;
        longint t;
        r.dbz = 1'b0;
        r.q   = '0;
        if (y == 0) begin
            r.q   = '1;
            r.dbz = 1'b1;
            return r;
        end
        if (x == 0) return r;
        k1 = 0;
        k2 = 0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) k1 = i;
            if (y[i]) k2 = i;
        end
        f1 = real'(x) / pow2(k1) - 1.0;
        f2 = real'(y) / pow2(k2) - 1.0;
        if (f1 >= f2) v = pow2(k1 - k2) * (1.0 + f1 - f2);
        else          v = pow2(k1 - k2 - 1) * (2.0 + f1 - f2);
        s = v * pow2(FRAC);
`ifdef MITCH_DIV_ROUND_EN
        s = s + 0.5;
`endif
        t = longint'($floor(s));
        if (t > ((64'd1 << QW) - 1)) r.q = '1;
        else                         r.q = t[QW-1:0];
        return r;
    endfunction

    function automatic res_t mk(input logic [QW-1:0] qv, input logic d);
        res_t r;
        r.q   = qv;
        r.dbz = d;
        return r;
    endfunction

    task automatic send(input logic [W-1:0] ai, input logic [W-1:0] bi, input res_t e);
        int g = 0;
        @(negedge clk);
        a = ai;
        b = bi;
        in_valid = 1'b1;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required 1");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        n_chk++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d results still pending, required 0", exp_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        #3;
        n_chk++;
        if ({out_valid, dbz, q} !== '0)
            $display("FAIL reset_outputs: got out_valid=%b dbz=%b q=%h, required all 0", out_valid, dbz, q);
        else
            n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        else
            n_pass++;
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        send(16'd100, 16'd10, mk(24'h000A80, 1'b0));
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (out_valid !== (i == 3))
                $display("FAIL latency_edge%0d: got out_valid=%b, required %b", i, out_valid, (i == 3));
            else
                n_pass++;
        end
        send(16'd1000, 16'd1000, mk(24'h000100, 1'b0));
        drain();
    endtask

    task automatic test_borrow();
        send(16'd2,     16'd3, mk(24'h0000C0, 1'b0));
        send(16'd3,     16'd2, mk(24'h000180, 1'b0));
        send(16'd65535, 16'd1, mk(24'hFFFF00, 1'b0));
        drain();
    endtask

    task automatic test_special();
        send(16'd7, 16'd0, mk(24'hFFFFFF, 1'b1));
        send(16'd0, 16'd0, mk(24'hFFFFFF, 1'b1));
        send(16'd0, 16'd5, mk(24'h000000, 1'b0));
        drain();
    endtask

    task automatic test_round();
`ifdef MITCH_DIV_ROUND_EN
        send(16'd1, 16'd384, mk(24'h000001, 1'b0));
`else
        send(16'd1, 16'd384, mk(24'h000000, 1'b0));
`endif
        send(16'd1, 16'd65535, model(16'd1, 16'd65535));
        drain();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [W-1:0] ra, rb;
                    ra = W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
                    rb = ($urandom_range(0, 7) == 0) ? '0
                         : W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
                    send(ra, rb, model(ra, rb));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va[5] = '{16'd100, 16'd3, 16'd50000, 16'd777, 16'd9};
        logic [W-1:0] vb[5] = '{16'd7, 16'd5, 16'd3, 16'd0, 16'd9000};
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) send(va[i], vb[i], model(va[i], vb[i]));
            end
            begin
                int g = 0;
                logic [QW-1:0] q0;
                do begin
                    @(posedge clk);
                    #1;
                    g++;
                end while (!out_valid && g < 50);
                out_ready = 1'b0;
                #1;
                n_chk++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1)
                    $display("FAIL stall_entry: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
                else
                    n_pass++;
                q0 = q;
                repeat (4) begin
                    @(negedge clk);
                    n_chk++;
                    if (q !== q0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                        $display("FAIL stall_hold: got q=%h out_valid=%b in_ready=%b, required q=%h 1 0",
                                 q, out_valid, in_ready, q0);
                    else
                        n_pass++;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_midflight();
        bit seen = 1'b0;
        out_ready = 1'b1;
        send(16'd100, 16'd10, mk(24'h000A80, 1'b0));
        send(16'd3,   16'd2,  mk(24'h000180, 1'b0));
        rst = 1'b1;
        #1;
        exp_q.delete();
        n_chk++;
        if (out_valid !== 1'b0 || q !== '0)
            $display("FAIL midflight_reset: got out_valid=%b q=%h, required 0 000000", out_valid, q);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        n_chk++;
        if (seen)
            $display("FAIL stale_result: got out_valid=1 after reset, required 0");
        else
            n_pass++;
        send(16'd1000, 16'd1000, mk(24'h000100, 1'b0));
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (out_valid !== (i == 3))
                $display("FAIL post_reset_latency%0d: got out_valid=%b, required %b", i, out_valid, (i == 3));
            else
                n_pass++;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_borrow();
        test_special();
        test_round();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
